mem_stage: RTL and testbench

- Memory-access stage of the 5-stage RV32 pipeline. It sits between the EX/MEM register and writeback.
- Takes the registered execute results (operation, address, store data, ALU result), performs load/store transactions on a req/gnt/rvalid data-memory port, and formats load data.
- Stalls the front of the pipeline while a transaction is outstanding and registers the MEM/WB pipeline outputs.

---
 rtl/mem_stage.sv | 205 ++++++++++++++++++++
 tb/tb_mem_stage.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// RV32 memory-access stage: drives the req/gnt/rvalid data-memory port,
// formats load data and registers the MEM/WB pipeline outputs.

package riscv_pkg;
    typedef enum logic [4:0] {
        ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU,
        LUI, AUIPC, JAL, JALR, BEQ, BNE, BLT, BGE, BLTU, BGEU,
        LB, LH, LW, LBU, LHU, SB, SH, SW
    } alu_ctrl_e;
endpackage

module mem_stage
    import riscv_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            tb_update_i,
    output logic            tb_update_o,
    input  logic [XLEN-1:0] pcM_i,
    input  logic [XLEN-1:0] instrM_i,
    input  alu_ctrl_e       operationM_i,
    input  logic [XLEN-1:0] rdM_data_i,
    input  logic [4:0]      rdM_addr_i,
    input  logic            rdM_wr_ena_i,
    input  logic            memM_wr_ena_i,
    input  logic [XLEN-1:0] memM_addr_i,
    input  logic [XLEN-1:0] memM_wr_data_i,
    output logic            dmem_req_o,
    output logic            dmem_we_o,
    output logic [XLEN-1:0] dmem_addr_o,
    output logic [3:0]      dmem_be_o,
    output logic [XLEN-1:0] dmem_wdata_o,
    input  logic            dmem_gnt_i,
    input  logic            dmem_rvalid_i,
    input  logic [XLEN-1:0] dmem_rdata_i,
    output logic            stall_o,
    output logic [XLEN-1:0] forwM_data_o,
    output logic [XLEN-1:0] pcM_o,
    output logic [XLEN-1:0] instrM_o,
    output logic [XLEN-1:0] rdM_data_o,
    output logic [4:0]      rdM_addr_o,
    output logic            rdM_wr_ena_o,
    output logic            misaligned_o
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

    state_e          r_state;
    state_e          w_nextState;
    alu_ctrl_e       r_latOp;
    logic [1:0]      r_latOff;
    logic            w_isLoad, w_isStoreOp, w_isStore, w_isHalf, w_isWord;
    logic            w_memOp, w_misaligned, w_aligned;
    logic            w_req, w_grant, w_done;
    logic [3:0]      w_be;
    logic [XLEN-1:0] w_wdata, w_loadData;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;

    always_comb begin
        w_isLoad    = 1'b0;
        w_isStoreOp = 1'b0;
        w_isHalf    = 1'b0;
        w_isWord    = 1'b0;
        case (operationM_i)
            LB, LBU: w_isLoad = 1'b1;
            LH, LHU: begin w_isLoad = 1'b1; w_isHalf = 1'b1; end
            LW:      begin w_isLoad = 1'b1; w_isWord = 1'b1; end
            SB:      w_isStoreOp = 1'b1;
            SH:      begin w_isStoreOp = 1'b1; w_isHalf = 1'b1; end
            SW:      begin w_isStoreOp = 1'b1; w_isWord = 1'b1; end
            default: ;
        endcase
    end

    assign w_isStore    = w_isStoreOp & memM_wr_ena_i;
    assign w_memOp      = w_isLoad | w_isStore;
    assign w_misaligned = w_memOp & ((w_isHalf & memM_addr_i[0]) | (w_isWord & (|memM_addr_i[1:0])));
    assign w_aligned    = w_memOp & ~w_misaligned;

    // The EX/MEM inputs are frozen by stall_o, so REQ/WAIT can keep using them directly.
    always_comb begin
        w_nextState = r_state;
        w_req       = 1'b0;
        w_grant     = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_aligned) begin
                    w_req = 1'b1;
                    if (dmem_gnt_i) begin
                        w_grant = 1'b1;
                        if (w_isStore) w_done = 1'b1;
                        else           w_nextState = WAIT;
                    end else begin
                        w_nextState = REQ;
                    end
                end
            end
            REQ: begin
                w_req = 1'b1;
                if (dmem_gnt_i) begin
                    w_grant = 1'b1;
                    if (w_isStore) begin
                        w_done      = 1'b1;
                        w_nextState = IDLE;
                    end else begin
                        w_nextState = WAIT;
                    end
                end
            end
            WAIT: begin
                if (dmem_rvalid_i) begin
                    w_done      = 1'b1;
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= IDLE;
            r_latOp  <= ADD;
            r_latOff <= 2'b00;
        end else begin
            r_state <= w_nextState;
            if (w_grant) begin
                r_latOp  <= operationM_i;
                r_latOff <= memM_addr_i[1:0];
            end
        end
    end

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = memM_wr_data_i;
        case (operationM_i)
            SB: begin
                w_be    = 4'b0001 << memM_addr_i[1:0];
                w_wdata = {4{memM_wr_data_i[7:0]}};
            end
            SH: begin
                w_be    = memM_addr_i[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{memM_wr_data_i[15:0]}};
            end
            default: ;
        endcase
    end

    assign w_byte = dmem_rdata_i[{r_latOff, 3'b000} +: 8];
    assign w_half = r_latOff[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];

    always_comb begin
        w_loadData = dmem_rdata_i;
        case (r_latOp)
            LB:      w_loadData = {{24{w_byte[7]}}, w_byte};
            LBU:     w_loadData = {24'h0, w_byte};
            LH:      w_loadData = {{16{w_half[15]}}, w_half};
            LHU:     w_loadData = {16'h0, w_half};
            default: ;
        endcase
    end

    assign dmem_req_o   = w_req & ~rst_i;
    assign dmem_we_o    = w_isStore;
    assign dmem_addr_o  = {memM_addr_i[XLEN-1:2], 2'b00};
    assign dmem_be_o    = w_be;
    assign dmem_wdata_o = w_wdata;
    assign stall_o      = w_aligned & ~w_done;
    assign forwM_data_o = rdM_data_i;

    // While stalled a bubble enters WB; data-path fields keep their old value.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pcM_o        <= RESET_PC;
            instrM_o     <= 32'h0000_0013;
            rdM_data_o   <= '0;
            rdM_addr_o   <= '0;
            rdM_wr_ena_o <= 1'b0;
            tb_update_o  <= 1'b0;
            misaligned_o <= 1'b0;
        end else if (stall_o) begin
            instrM_o     <= 32'h0000_0013;
            rdM_wr_ena_o <= 1'b0;
            tb_update_o  <= 1'b0;
            misaligned_o <= 1'b0;
        end else begin
            pcM_o        <= pcM_i;
            instrM_o     <= instrM_i;
            rdM_data_o   <= w_isLoad ? w_loadData : rdM_data_i;
            rdM_addr_o   <= rdM_addr_i;
            tb_update_o  <= tb_update_i;
            misaligned_o <= w_misaligned;
            if (w_misaligned || w_isStore) rdM_wr_ena_o <= 1'b0;
            else if (w_isLoad)             rdM_wr_ena_o <= rdM_wr_ena_i & (|rdM_addr_i);
            else                           rdM_wr_ena_o <= rdM_wr_ena_i;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a vector table of single-cycle operations
// plus hand-written load, delayed-grant and reset-in-flight sequences.

module tb_mem_stage;
    import riscv_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        tbUpdI, tbUpdO;
    logic [31:0] pcI, instrI, rdDataI, memAddr, memWdata;
    alu_ctrl_e   opI;
    logic [4:0]  rdAddrI, rdAddrO;
    logic        rdWrEnaI, memWrEna;
    logic        req, we, gnt, rvalid;
    logic [31:0] dAddr, dWdata, rdata;
    logic [3:0]  be;
    logic        stall, rdWrEnaO, misO;
    logic [31:0] forw, pcO, instrO, rdDataO;

    int passCount  = 0;
    int checkCount = 0;

    typedef struct {
        alu_ctrl_e   op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdData;
        logic [4:0]  rdAddr;
        logic        rdWrEna;
        logic        memWrEna;
        logic        expReq;
        logic [31:0] expAddr;
        logic [3:0]  expBe;
        logic [31:0] expWdata;
        logic [31:0] expRdData;
        logic        expWrEna;
        logic        expMis;
    } vec_t;

    vec_t vecs [12];

    always #5 clk = ~clk;

    mem_stage #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
        .clk_i(clk), .rst_i(rst),
        .tb_update_i(tbUpdI), .tb_update_o(tbUpdO),
        .pcM_i(pcI), .instrM_i(instrI), .operationM_i(opI),
        .rdM_data_i(rdDataI), .rdM_addr_i(rdAddrI), .rdM_wr_ena_i(rdWrEnaI),
        .memM_wr_ena_i(memWrEna), .memM_addr_i(memAddr), .memM_wr_data_i(memWdata),
        .dmem_req_o(req), .dmem_we_o(we), .dmem_addr_o(dAddr), .dmem_be_o(be),
        .dmem_wdata_o(dWdata), .dmem_gnt_i(gnt), .dmem_rvalid_i(rvalid),
        .dmem_rdata_i(rdata), .stall_o(stall), .forwM_data_o(forw),
        .pcM_o(pcO), .instrM_o(instrO), .rdM_data_o(rdDataO),
        .rdM_addr_o(rdAddrO), .rdM_wr_ena_o(rdWrEnaO), .misaligned_o(misO)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: actual=%h expected=%h", name, actual, expected);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setNop();
        opI = ADD; memAddr = '0; memWdata = '0; rdDataI = '0; rdAddrI = '0;
        rdWrEnaI = 1'b0; memWrEna = 1'b0; tbUpdI = 1'b0; gnt = 1'b0;
        rvalid = 1'b0; rdata = '0; pcI = '0; instrI = 32'h13;
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        opI = v.op; memAddr = v.addr; memWdata = v.wdata; rdDataI = v.rdData;
        rdAddrI = v.rdAddr; rdWrEnaI = v.rdWrEna; memWrEna = v.memWrEna;
        tbUpdI = 1'b1; gnt = 1'b1; rvalid = 1'b0; rdata = '0;
        pcI = 32'h1000 + 32'(idx) * 4; instrI = 32'h100 + 32'(idx);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, " pc"}, pcO, RESET_PC);
        checkOutput({tag, " instr"}, instrO, 32'h13);
        checkOutput({tag, " rdData"}, rdDataO, 32'h0);
        checkOutput({tag, " rdAddr"}, 32'(rdAddrO), 32'h0);
        checkOutput({tag, " wrEna"}, 32'(rdWrEnaO), 32'h0);
        checkOutput({tag, " tbUpd"}, 32'(tbUpdO), 32'h0);
        checkOutput({tag, " mis"}, 32'(misO), 32'h0);
    endtask

    // Load with immediate grant and rvalid on the following cycle.
    task automatic runLoad(input alu_ctrl_e o, input logic [31:0] a, input logic [31:0] expAddr,
                           input logic [4:0] rd, input logic [31:0] word, input logic [31:0] expData,
                           input logic expWe, input string tag);
        setNop();
        opI = o; memAddr = a; rdAddrI = rd; rdWrEnaI = 1'b1; tbUpdI = 1'b1;
        instrI = 32'h0000_2003; pcI = 32'h2000; gnt = 1'b1;
        #1;
        checkOutput({tag, " req"}, 32'(req), 32'h1);
        checkOutput({tag, " we"}, 32'(we), 32'h0);
        checkOutput({tag, " be"}, 32'(be), 32'hF);
        checkOutput({tag, " addr"}, dAddr, expAddr);
        checkOutput({tag, " stall0"}, 32'(stall), 32'h1);
        tick();
        checkOutput({tag, " bubbleWe"}, 32'(rdWrEnaO), 32'h0);
        checkOutput({tag, " bubbleInstr"}, instrO, 32'h13);
        gnt = 1'b0; rvalid = 1'b1; rdata = word;
        #1;
        checkOutput({tag, " reqWait"}, 32'(req), 32'h0);
        checkOutput({tag, " stall1"}, 32'(stall), 32'h0);
        tick();
        checkOutput({tag, " data"}, rdDataO, expData);
        checkOutput({tag, " wrEna"}, 32'(rdWrEnaO), 32'(expWe));
        checkOutput({tag, " tbUpd"}, 32'(tbUpdO), 32'h1);
        setNop();
    endtask

    initial begin
        string tag;
        int stallCycles, writeBacks;

        //          op   addr           wdata          rdData         rd  wr mw  req addr          be       wdata          expData        we mis
        vecs[0]  = '{ADD, 32'h0,        32'h0,        32'h0000_1234, 5'd5, 1, 0, 0, 32'h0,        4'h0,    32'h0,        32'h0000_1234, 1, 0};
        vecs[1]  = '{SB,  32'h8000_0103,32'hAABB_CCDD,32'h8000_0103, 5'd0, 1, 1, 1, 32'h8000_0100,4'b1000, 32'hDDDD_DDDD,32'h8000_0103, 0, 0};
        vecs[2]  = '{SH,  32'h1000_0002,32'h1234_5678,32'h1000_0002, 5'd0, 0, 1, 1, 32'h1000_0000,4'b1100, 32'h5678_5678,32'h1000_0002, 0, 0};
        vecs[3]  = '{SH,  32'h1000_0004,32'h1234_5678,32'h1000_0004, 5'd0, 0, 1, 1, 32'h1000_0004,4'b0011, 32'h5678_5678,32'h1000_0004, 0, 0};
        vecs[4]  = '{SW,  32'h2000_0008,32'hCAFE_F00D,32'h2000_0008, 5'd0, 0, 1, 1, 32'h2000_0008,4'b1111, 32'hCAFE_F00D,32'h2000_0008, 0, 0};
        vecs[5]  = '{SB,  32'h3000_0000,32'h0000_0011,32'h3000_0000, 5'd0, 0, 1, 1, 32'h3000_0000,4'b0001, 32'h1111_1111,32'h3000_0000, 0, 0};
        vecs[6]  = '{LH,  32'h4000_0001,32'h0,        32'h4000_0001, 5'd3, 1, 0, 0, 32'h0,        4'h0,    32'h0,        32'h0,         0, 1};
        vecs[7]  = '{SW,  32'h5000_0006,32'h0000_0001,32'h5000_0006, 5'd0, 0, 1, 0, 32'h0,        4'h0,    32'h0,        32'h0,         0, 1};
        vecs[8]  = '{LW,  32'h6000_0003,32'h0,        32'h6000_0003, 5'd4, 1, 0, 0, 32'h0,        4'h0,    32'h0,        32'h0,         0, 1};
        vecs[9]  = '{ADD, 32'h0,        32'h0,        32'h0000_0055, 5'd0, 1, 0, 0, 32'h0,        4'h0,    32'h0,        32'h0000_0055, 1, 0};
        vecs[10] = '{SB,  32'h7000_0001,32'h0000_00EE,32'h0000_0077, 5'd4, 1, 0, 0, 32'h0,        4'h0,    32'h0,        32'h0000_0077, 1, 0};
        vecs[11] = '{SLT, 32'h0,        32'h0,        32'h0000_0001, 5'd2, 0, 0, 0, 32'h0,        4'h0,    32'h0,        32'h0000_0001, 0, 0};

        rst = 1'b1;
        setNop();
        repeat (2) @(posedge clk);
        #1;
        checkResetState("reset");
        checkOutput("reset req", 32'(req), 32'h0);
        checkOutput("reset stall", 32'(stall), 32'h0);
        rst = 1'b0;

        // Single-cycle operations from the table
        for (int i = 0; i < 12; i++) begin
            tag = $sformatf("vec%0d", i);
            applyStimulus(vecs[i], i);
            #1;
            checkOutput({tag, " stall"}, 32'(stall), 32'h0);
            checkOutput({tag, " req"}, 32'(req), 32'(vecs[i].expReq));
            checkOutput({tag, " forw"}, forw, vecs[i].rdData);
            if (vecs[i].expReq) begin
                checkOutput({tag, " we"}, 32'(we), 32'h1);
                checkOutput({tag, " addr"}, dAddr, vecs[i].expAddr);
                checkOutput({tag, " be"}, 32'(be), 32'(vecs[i].expBe));
                checkOutput({tag, " wdata"}, dWdata, vecs[i].expWdata);
            end
            tick();
            checkOutput({tag, " wrEna"}, 32'(rdWrEnaO), 32'(vecs[i].expWrEna));
            checkOutput({tag, " mis"}, 32'(misO), 32'(vecs[i].expMis));
            checkOutput({tag, " tbUpd"}, 32'(tbUpdO), 32'h1);
            checkOutput({tag, " pc"}, pcO, 32'h1000 + 32'(i) * 4);
            checkOutput({tag, " instr"}, instrO, 32'h100 + 32'(i));
            checkOutput({tag, " rdAddr"}, 32'(rdAddrO), 32'(vecs[i].rdAddr));
            if (!vecs[i].expMis)
                checkOutput({tag, " rdData"}, rdDataO, vecs[i].expRdData);
        end
        setNop();
        tick();
        checkOutput("misPulse", 32'(misO), 32'h0);

        // Loads with one stall cycle and data formatting
        runLoad(LB,  32'h0000_1002, 32'h0000_1000, 5'd7, 32'h0080_0000, 32'hFFFF_FF80, 1'b1, "lb");
        runLoad(LBU, 32'h0000_1002, 32'h0000_1000, 5'd7, 32'h0080_0000, 32'h0000_0080, 1'b1, "lbu");
        runLoad(LH,  32'h0000_1102, 32'h0000_1100, 5'd8, 32'h8001_0000, 32'hFFFF_8001, 1'b1, "lh");
        runLoad(LHU, 32'h0000_1102, 32'h0000_1100, 5'd8, 32'h8001_0000, 32'h0000_8001, 1'b1, "lhu");
        runLoad(LB,  32'h0000_1203, 32'h0000_1200, 5'd9, 32'h7F00_0000, 32'h0000_007F, 1'b1, "lbTop");
        runLoad(LW,  32'h0000_3000, 32'h0000_3000, 5'd0, 32'h1234_5678, 32'h1234_5678, 1'b0, "lwX0");

        // LW: grant after 3 cycles, rvalid 2 cycles after grant
        setNop();
        opI = LW; memAddr = 32'h0000_2004; rdAddrI = 5'd9; rdWrEnaI = 1'b1; tbUpdI = 1'b1;
        instrI = 32'h0041_2483; pcI = 32'h3000;
        stallCycles = 0;
        writeBacks  = 0;
        for (int c = 0; c < 7; c++) begin
            tag = $sformatf("lwSlow c%0d", c);
            gnt    = (c == 3);
            rvalid = (c == 5);
            rdata  = (c == 5) ? 32'hDEAD_BEEF : 32'h0;
            #1;
            if (stall) stallCycles++;
            if (c <= 3) begin
                checkOutput({tag, " req"}, 32'(req), 32'h1);
                checkOutput({tag, " addr"}, dAddr, 32'h0000_2004);
                checkOutput({tag, " be"}, 32'(be), 32'hF);
            end
            tick();
            if (rdWrEnaO) writeBacks++;
            if (c < 5) begin
                checkOutput({tag, " bubble"}, instrO, 32'h13);
            end else if (c == 5) begin
                checkOutput({tag, " data"}, rdDataO, 32'hDEAD_BEEF);
                checkOutput({tag, " instr"}, instrO, 32'h0041_2483);
                setNop();
            end
        end
        checkOutput("lwSlow stallCycles", 32'(stallCycles), 32'd5);
        checkOutput("lwSlow writeBacks", 32'(writeBacks), 32'd1);

        // Reset while waiting for read data, then a stray rvalid
        setNop();
        opI = LW; memAddr = 32'h7000_0000; rdAddrI = 5'd6; rdWrEnaI = 1'b1; tbUpdI = 1'b1; gnt = 1'b1;
        tick();
        gnt = 1'b0;
        #1;
        checkOutput("rstWait stallBefore", 32'(stall), 32'h1);
        rst = 1'b1;
        setNop();
        tick();
        checkResetState("rstWait");
        rst = 1'b0;
        rvalid = 1'b1; rdata = 32'hFFFF_FFFF;
        #1;
        checkOutput("stray stall", 32'(stall), 32'h0);
        checkOutput("stray req", 32'(req), 32'h0);
        tick();
        checkOutput("stray wrEna", 32'(rdWrEnaO), 32'h0);
        checkOutput("stray tbUpd", 32'(tbUpdO), 32'h0);
        runLoad(LB, 32'h7000_0001, 32'h7000_0000, 5'd8, 32'h0000_FF00, 32'hFFFF_FFFF, 1'b1, "afterRst");

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
